// File: rtl/rdata_return_mux_pkg.sv
// ============================================================================
// Module   : rdata_return_mux_pkg
// Brief    : Shared types and constants for the AXI R-channel return crossbar.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rdata_return_mux_pkg;

  localparam int R_NUM_SLAVES    = 3;
  localparam int AXI_MASTER_0_ID = 0;
  localparam int AXI_MASTER_1_ID = 1;

  typedef enum logic [1:0] {
    R_IDLE    = 2'd0,
    R_LOCK_S0 = 2'd1,
    R_LOCK_S1 = 2'd2,
    R_LOCK_S2 = 2'd3
  } rdata_lock_t;

  function automatic rdata_lock_t lock_of(input logic [1:0] idx);
    case (idx)
      2'd0:    return R_LOCK_S0;
      2'd1:    return R_LOCK_S1;
      default: return R_LOCK_S2;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/rdata_master_port.sv
// ============================================================================
// Module   : rdata_master_port
// Brief    : Per-master burst lock FSM, slave arbiter and R-channel output mux.
//            Optional round-robin arbitration under macro RDATA_RR_ARB_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rdata_master_port
  import rdata_return_mux_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ID_W      = 4,
  parameter int IDS_W     = 8,
  parameter int MASTER_ID = 0
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [R_NUM_SLAVES-1:0][IDS_W-1:0]      rid_s_i,
  input  logic [R_NUM_SLAVES-1:0][DATA_W-1:0]     rdata_s_i,
  input  logic [R_NUM_SLAVES-1:0][1:0]            rresp_s_i,
  input  logic [R_NUM_SLAVES-1:0]                 rlast_s_i,
  input  logic [R_NUM_SLAVES-1:0]                 rvalid_s_i,
  output logic [R_NUM_SLAVES-1:0]                 rready_s_o,
  output logic [R_NUM_SLAVES-1:0]                 lock_o,
  output logic [ID_W-1:0]                         rid_m_o,
  output logic [DATA_W-1:0]                       rdata_m_o,
  output logic [1:0]                              rresp_m_o,
  output logic                                    rlast_m_o,
  output logic                                    rvalid_m_o,
  input  logic                                    rready_m_i
);

  localparam int MID_W = IDS_W - ID_W;

  rdata_lock_t               state_q;
  logic [R_NUM_SLAVES-1:0]   w_target;
  logic [1:0]                w_sel;
  logic                      w_gnt;
  logic                      w_hs;
  logic                      w_last;

  for (genvar x = 0; x < R_NUM_SLAVES; x++) begin : g_target
    assign w_target[x] = rvalid_s_i[x] &&
                         (rid_s_i[x][IDS_W-1:ID_W] == MID_W'(MASTER_ID));
  end

  assign lock_o = {state_q == R_LOCK_S2, state_q == R_LOCK_S1, state_q == R_LOCK_S0};
  assign w_hs   = w_gnt & rready_m_i;
  assign w_last = rlast_s_i[w_sel];

`ifdef RDATA_RR_ARB_EN
  logic [1:0] ptr_q;
  logic [1:0] ptr_d;

  // Pointer advances only when a burst completes, so a lock is never cut short.
  assign ptr_d = (w_sel == 2'd2) ? 2'd0 : w_sel + 2'd1;

  always_ff @(posedge clk) begin
    if (rst)                 ptr_q <= 2'd0;
    else if (w_hs && w_last) ptr_q <= ptr_d;
  end
`endif

  always_comb begin
    w_sel = 2'd0;
    w_gnt = 1'b0;
    case (state_q)
      R_IDLE: begin
        // Descending scan: the last hit is the highest-priority slave.
        for (int k = R_NUM_SLAVES - 1; k >= 0; k--) begin
`ifdef RDATA_RR_ARB_EN
          if (w_target[(int'(ptr_q) + k) % R_NUM_SLAVES]) begin
            w_sel = 2'((int'(ptr_q) + k) % R_NUM_SLAVES);
            w_gnt = 1'b1;
          end
`else
          if (w_target[k]) begin
            w_sel = 2'(k);
            w_gnt = 1'b1;
          end
`endif
        end
      end
      R_LOCK_S0: begin w_sel = 2'd0; w_gnt = w_target[0]; end
      R_LOCK_S1: begin w_sel = 2'd1; w_gnt = w_target[1]; end
      default:   begin w_sel = 2'd2; w_gnt = w_target[2]; end
    endcase
    if (rst) w_gnt = 1'b0;
  end

  always_comb begin
    rid_m_o    = '0;
    rdata_m_o  = '0;
    rresp_m_o  = '0;
    rlast_m_o  = 1'b0;
    rvalid_m_o = 1'b0;
    rready_s_o = '0;
    if (w_gnt) begin
      rid_m_o           = rid_s_i[w_sel][ID_W-1:0];
      rdata_m_o         = rdata_s_i[w_sel];
      rresp_m_o         = rresp_s_i[w_sel];
      rlast_m_o         = w_last;
      rvalid_m_o        = 1'b1;
      rready_s_o[w_sel] = rready_m_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= R_IDLE;
    end else if (w_hs) begin
      if (w_last) state_q <= R_IDLE;
      else        state_q <= lock_of(w_sel);
    end
  end

endmodule

`default_nettype wire

// File: rtl/rdata_return_mux.sv
// ============================================================================
// Module   : rdata_return_mux
// Brief    : AXI R-channel return crossbar, slaves S0..S2 to masters M0/M1,
//            with unmapped-ID sink. Macro RDATA_RR_ARB_EN selects round-robin.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rdata_return_mux
  import rdata_return_mux_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int IDS_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDS_W-1:0]  RID_S0,
  input  logic [DATA_W-1:0] RDATA_S0,
  input  logic [1:0]        RRESP_S0,
  input  logic              RLAST_S0,
  input  logic              RVALID_S0,
  output logic              RREADY_S0,
  input  logic [IDS_W-1:0]  RID_S1,
  input  logic [DATA_W-1:0] RDATA_S1,
  input  logic [1:0]        RRESP_S1,
  input  logic              RLAST_S1,
  input  logic              RVALID_S1,
  output logic              RREADY_S1,
  input  logic [IDS_W-1:0]  RID_S2,
  input  logic [DATA_W-1:0] RDATA_S2,
  input  logic [1:0]        RRESP_S2,
  input  logic              RLAST_S2,
  input  logic              RVALID_S2,
  output logic              RREADY_S2,
  output logic [ID_W-1:0]   RID_M0,
  output logic [DATA_W-1:0] RDATA_M0,
  output logic [1:0]        RRESP_M0,
  output logic              RLAST_M0,
  output logic              RVALID_M0,
  input  logic              RREADY_M0,
  output logic [ID_W-1:0]   RID_M1,
  output logic [DATA_W-1:0] RDATA_M1,
  output logic [1:0]        RRESP_M1,
  output logic              RLAST_M1,
  output logic              RVALID_M1,
  input  logic              RREADY_M1,
  output logic              unmapped_err
);

  localparam int MID_W = IDS_W - ID_W;

  logic [R_NUM_SLAVES-1:0][IDS_W-1:0]  w_rid;
  logic [R_NUM_SLAVES-1:0][DATA_W-1:0] w_rdata;
  logic [R_NUM_SLAVES-1:0][1:0]        w_rresp;
  logic [R_NUM_SLAVES-1:0]             w_rlast;
  logic [R_NUM_SLAVES-1:0]             w_rvalid;
  logic [R_NUM_SLAVES-1:0]             w_rready_m0;
  logic [R_NUM_SLAVES-1:0]             w_rready_m1;
  logic [R_NUM_SLAVES-1:0]             w_lock_m0;
  logic [R_NUM_SLAVES-1:0]             w_lock_m1;
  logic [R_NUM_SLAVES-1:0]             w_unmapped;
  logic [R_NUM_SLAVES-1:0]             w_sink;
  logic                                w_taken;

  assign w_rid    = {RID_S2,    RID_S1,    RID_S0};
  assign w_rdata  = {RDATA_S2,  RDATA_S1,  RDATA_S0};
  assign w_rresp  = {RRESP_S2,  RRESP_S1,  RRESP_S0};
  assign w_rlast  = {RLAST_S2,  RLAST_S1,  RLAST_S0};
  assign w_rvalid = {RVALID_S2, RVALID_S1, RVALID_S0};

  rdata_master_port #(
    .DATA_W(DATA_W), .ID_W(ID_W), .IDS_W(IDS_W), .MASTER_ID(AXI_MASTER_0_ID)
  ) u_port_m0 (
    .clk(clk), .rst(rst),
    .rid_s_i(w_rid), .rdata_s_i(w_rdata), .rresp_s_i(w_rresp),
    .rlast_s_i(w_rlast), .rvalid_s_i(w_rvalid),
    .rready_s_o(w_rready_m0), .lock_o(w_lock_m0),
    .rid_m_o(RID_M0), .rdata_m_o(RDATA_M0), .rresp_m_o(RRESP_M0),
    .rlast_m_o(RLAST_M0), .rvalid_m_o(RVALID_M0), .rready_m_i(RREADY_M0)
  );

  rdata_master_port #(
    .DATA_W(DATA_W), .ID_W(ID_W), .IDS_W(IDS_W), .MASTER_ID(AXI_MASTER_1_ID)
  ) u_port_m1 (
    .clk(clk), .rst(rst),
    .rid_s_i(w_rid), .rdata_s_i(w_rdata), .rresp_s_i(w_rresp),
    .rlast_s_i(w_rlast), .rvalid_s_i(w_rvalid),
    .rready_s_o(w_rready_m1), .lock_o(w_lock_m1),
    .rid_m_o(RID_M1), .rdata_m_o(RDATA_M1), .rresp_m_o(RRESP_M1),
    .rlast_m_o(RLAST_M1), .rvalid_m_o(RVALID_M1), .rready_m_i(RREADY_M1)
  );

  for (genvar x = 0; x < R_NUM_SLAVES; x++) begin : g_unmapped
    assign w_unmapped[x] = !rst && w_rvalid[x] && !w_lock_m0[x] && !w_lock_m1[x] &&
                           (w_rid[x][IDS_W-1:ID_W] != MID_W'(AXI_MASTER_0_ID)) &&
                           (w_rid[x][IDS_W-1:ID_W] != MID_W'(AXI_MASTER_1_ID));
  end

  // At most one beat is discarded per cycle, lowest slave index first.
  always_comb begin
    w_sink  = '0;
    w_taken = 1'b0;
    for (int k = 0; k < R_NUM_SLAVES; k++) begin
      if (w_unmapped[k] && !w_taken) begin
        w_sink[k] = 1'b1;
        w_taken   = 1'b1;
      end
    end
  end

  assign RREADY_S0    = w_rready_m0[0] | w_rready_m1[0] | w_sink[0];
  assign RREADY_S1    = w_rready_m0[1] | w_rready_m1[1] | w_sink[1];
  assign RREADY_S2    = w_rready_m0[2] | w_rready_m1[2] | w_sink[2];
  assign unmapped_err = |w_sink;

endmodule

`default_nettype wire

// File: tb/tb_rdata_return_mux.sv
// ============================================================================
// Module   : tb_rdata_return_mux
// Brief    : Directed self-checking bench for the R-channel return crossbar.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rdata_return_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  RID_S0, RID_S1, RID_S2;
  logic [31:0] RDATA_S0, RDATA_S1, RDATA_S2;
  logic [1:0]  RRESP_S0, RRESP_S1, RRESP_S2;
  logic        RLAST_S0, RLAST_S1, RLAST_S2;
  logic        RVALID_S0, RVALID_S1, RVALID_S2;
  logic        RREADY_S0, RREADY_S1, RREADY_S2;
  logic [3:0]  RID_M0, RID_M1;
  logic [31:0] RDATA_M0, RDATA_M1;
  logic [1:0]  RRESP_M0, RRESP_M1;
  logic        RLAST_M0, RLAST_M1, RVALID_M0, RVALID_M1;
  logic        RREADY_M0, RREADY_M1;
  logic        unmapped_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rdata_return_mux #(.DATA_W(32), .ID_W(4), .IDS_W(8)) dut (
    .clk(clk), .rst(rst),
    .RID_S0(RID_S0), .RDATA_S0(RDATA_S0), .RRESP_S0(RRESP_S0), .RLAST_S0(RLAST_S0),
    .RVALID_S0(RVALID_S0), .RREADY_S0(RREADY_S0),
    .RID_S1(RID_S1), .RDATA_S1(RDATA_S1), .RRESP_S1(RRESP_S1), .RLAST_S1(RLAST_S1),
    .RVALID_S1(RVALID_S1), .RREADY_S1(RREADY_S1),
    .RID_S2(RID_S2), .RDATA_S2(RDATA_S2), .RRESP_S2(RRESP_S2), .RLAST_S2(RLAST_S2),
    .RVALID_S2(RVALID_S2), .RREADY_S2(RREADY_S2),
    .RID_M0(RID_M0), .RDATA_M0(RDATA_M0), .RRESP_M0(RRESP_M0), .RLAST_M0(RLAST_M0),
    .RVALID_M0(RVALID_M0), .RREADY_M0(RREADY_M0),
    .RID_M1(RID_M1), .RDATA_M1(RDATA_M1), .RRESP_M1(RRESP_M1), .RLAST_M1(RLAST_M1),
    .RVALID_M1(RVALID_M1), .RREADY_M1(RREADY_M1),
    .unmapped_err(unmapped_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int x, input logic [7:0] id, input logic [31:0] d,
                       input logic last, input logic vld);
    case (x)
      0:       begin RID_S0 = id; RDATA_S0 = d; RLAST_S0 = last; RVALID_S0 = vld; end
      1:       begin RID_S1 = id; RDATA_S1 = d; RLAST_S1 = last; RVALID_S1 = vld; end
      default: begin RID_S2 = id; RDATA_S2 = d; RLAST_S2 = last; RVALID_S2 = vld; end
    endcase
  endtask

  task automatic idle_all;
    drive(0, 8'h00, 32'h0, 1'b0, 1'b0);
    drive(1, 8'h00, 32'h0, 1'b0, 1'b0);
    drive(2, 8'h00, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    rst = 1'b1; RREADY_M0 = 1'b1; RREADY_M1 = 1'b1;
    RRESP_S0 = 2'b00; RRESP_S1 = 2'b00; RRESP_S2 = 2'b00;
    idle_all();
    drive(0, 8'h01, 32'h11, 1'b1, 1'b1);
    drive(2, 8'hF0, 32'h22, 1'b1, 1'b1);
    #1;
    n_cmp++; if (RVALID_M0 !== 1'b0) begin n_bad++; $display("FAIL rst_rvalid_m0: got %b want 0", RVALID_M0); end
    n_cmp++; if (RREADY_S0 !== 1'b0) begin n_bad++; $display("FAIL rst_rready_s0: got %b want 0", RREADY_S0); end
    n_cmp++; if (RREADY_S2 !== 1'b0) begin n_bad++; $display("FAIL rst_rready_s2: got %b want 0", RREADY_S2); end
    n_cmp++; if (unmapped_err !== 1'b0) begin n_bad++; $display("FAIL rst_unmapped: got %b want 0", unmapped_err); end
    tick(); tick();
    rst = 1'b0; idle_all();
    #1;
    n_cmp++; if (RVALID_M1 !== 1'b0) begin n_bad++; $display("FAIL idle_rvalid_m1: got %b want 0", RVALID_M1); end
    n_cmp++; if (RDATA_M0 !== 32'h0) begin n_bad++; $display("FAIL idle_rdata_m0: got %h want 0", RDATA_M0); end
  endtask

  task automatic test_s1_burst;
    for (int b = 0; b < 4; b++) begin
      drive(1, 8'h13, 32'hA000_0000 + b, (b == 3), 1'b1);
      #1;
      n_cmp++; if (RVALID_M1 !== 1'b1) begin n_bad++; $display("FAIL burst_rvalid_m1[%0d]: got %b want 1", b, RVALID_M1); end
      n_cmp++; if (RID_M1 !== 4'h3) begin n_bad++; $display("FAIL burst_rid_m1[%0d]: got %h want 3", b, RID_M1); end
      n_cmp++; if (RDATA_M1 !== 32'hA000_0000 + b) begin n_bad++; $display("FAIL burst_rdata_m1[%0d]: got %h want %h", b, RDATA_M1, 32'hA000_0000 + b); end
      n_cmp++; if (RLAST_M1 !== (b == 3)) begin n_bad++; $display("FAIL burst_rlast_m1[%0d]: got %b want %b", b, RLAST_M1, (b == 3)); end
      n_cmp++; if (RREADY_S1 !== 1'b1) begin n_bad++; $display("FAIL burst_rready_s1[%0d]: got %b want 1", b, RREADY_S1); end
      n_cmp++; if (RVALID_M0 !== 1'b0) begin n_bad++; $display("FAIL burst_rvalid_m0[%0d]: got %b want 0", b, RVALID_M0); end
      tick();
    end
    // A beat from S0 only passes if M1 really returned to IDLE.
    drive(1, 8'h00, 32'h0, 1'b0, 1'b0);
    drive(0, 8'h1A, 32'h0000_C0DE, 1'b1, 1'b1);
    #1;
    n_cmp++; if (RDATA_M1 !== 32'h0000_C0DE) begin n_bad++; $display("FAIL burst_idle_rdata: got %h want 0000c0de", RDATA_M1); end
    n_cmp++; if (RID_M1 !== 4'hA) begin n_bad++; $display("FAIL burst_idle_rid: got %h want a", RID_M1); end
    tick();
    idle_all();
  endtask

  task automatic test_concurrent;
    RRESP_S2 = 2'b10;
    for (int b = 0; b < 2; b++) begin
      drive(0, 8'h01, 32'h5000_0000 + b, (b == 1), 1'b1);
      drive(2, 8'h12, 32'h7000_0000 + b, (b == 1), 1'b1);
      #1;
      n_cmp++; if (RDATA_M0 !== 32'h5000_0000 + b) begin n_bad++; $display("FAIL conc_rdata_m0[%0d]: got %h want %h", b, RDATA_M0, 32'h5000_0000 + b); end
      n_cmp++; if (RID_M0 !== 4'h1) begin n_bad++; $display("FAIL conc_rid_m0[%0d]: got %h want 1", b, RID_M0); end
      n_cmp++; if (RDATA_M1 !== 32'h7000_0000 + b) begin n_bad++; $display("FAIL conc_rdata_m1[%0d]: got %h want %h", b, RDATA_M1, 32'h7000_0000 + b); end
      n_cmp++; if (RID_M1 !== 4'h2) begin n_bad++; $display("FAIL conc_rid_m1[%0d]: got %h want 2", b, RID_M1); end
      n_cmp++; if (RRESP_M1 !== 2'b10) begin n_bad++; $display("FAIL conc_rresp_m1[%0d]: got %b want 10", b, RRESP_M1); end
      n_cmp++; if ({RREADY_S0, RREADY_S2} !== 2'b11) begin n_bad++; $display("FAIL conc_rready[%0d]: got %b want 11", b, {RREADY_S0, RREADY_S2}); end
      tick();
    end
    RRESP_S2 = 2'b00;
    idle_all();
  endtask

  task automatic test_priority;
    logic [31:0] exp_first, exp_second;
    logic [1:0]  exp_rdy;
    rst = 1'b1; tick(); rst = 1'b0;
    drive(0, 8'h05, 32'h0A, 1'b0, 1'b1);
    drive(1, 8'h06, 32'h1B, 1'b1, 1'b1);
    #1;
    n_cmp++; if (RDATA_M0 !== 32'h0A) begin n_bad++; $display("FAIL prio_first: got %h want 0a", RDATA_M0); end
    n_cmp++; if ({RREADY_S1, RREADY_S0} !== 2'b01) begin n_bad++; $display("FAIL prio_rdy1: got %b want 01", {RREADY_S1, RREADY_S0}); end
    tick();
    drive(0, 8'h05, 32'h0B, 1'b1, 1'b1);
    #1;
    n_cmp++; if (RDATA_M0 !== 32'h0B || RLAST_M0 !== 1'b1) begin n_bad++; $display("FAIL prio_lock: got %h/%b want 0b/1", RDATA_M0, RLAST_M0); end
    n_cmp++; if (RREADY_S1 !== 1'b0) begin n_bad++; $display("FAIL prio_lock_s1: got %b want 0", RREADY_S1); end
    tick();
    drive(0, 8'h05, 32'h0C, 1'b1, 1'b1);
`ifdef RDATA_RR_ARB_EN
    exp_first = 32'h1B; exp_second = 32'h0C; exp_rdy = 2'b10;
`else
    exp_first = 32'h0C; exp_second = 32'h1B; exp_rdy = 2'b01;
`endif
    #1;
    n_cmp++; if (RDATA_M0 !== exp_first) begin n_bad++; $display("FAIL prio_contend: got %h want %h", RDATA_M0, exp_first); end
    n_cmp++; if ({RREADY_S1, RREADY_S0} !== exp_rdy) begin n_bad++; $display("FAIL prio_contend_rdy: got %b want %b", {RREADY_S1, RREADY_S0}, exp_rdy); end
    tick();
`ifdef RDATA_RR_ARB_EN
    drive(1, 8'h00, 32'h0, 1'b0, 1'b0);
`else
    drive(0, 8'h00, 32'h0, 1'b0, 1'b0);
`endif
    #1;
    n_cmp++; if (RDATA_M0 !== exp_second || RVALID_M0 !== 1'b1) begin n_bad++; $display("FAIL prio_second: got %h/%b want %h/1", RDATA_M0, RVALID_M0, exp_second); end
    tick();
    idle_all();
  endtask

  task automatic test_backpressure;
    drive(0, 8'h07, 32'h100, 1'b0, 1'b1);
    #1;
    n_cmp++; if (RDATA_M0 !== 32'h100) begin n_bad++; $display("FAIL bp_beat1: got %h want 100", RDATA_M0); end
    tick();
    drive(0, 8'h07, 32'h101, 1'b0, 1'b1);
    drive(1, 8'h08, 32'h900, 1'b1, 1'b1);
    RREADY_M0 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++; if (RVALID_M0 !== 1'b1 || RDATA_M0 !== 32'h101) begin n_bad++; $display("FAIL bp_hold[%0d]: got %b/%h want 1/101", c, RVALID_M0, RDATA_M0); end
      n_cmp++; if ({RREADY_S1, RREADY_S0} !== 2'b00) begin n_bad++; $display("FAIL bp_rdy[%0d]: got %b want 00", c, {RREADY_S1, RREADY_S0}); end
      tick();
    end
    RREADY_M0 = 1'b1;
    #1;
    n_cmp++; if (RREADY_S0 !== 1'b1 || RDATA_M0 !== 32'h101) begin n_bad++; $display("FAIL bp_resume: got %b/%h want 1/101", RREADY_S0, RDATA_M0); end
    tick();
    drive(0, 8'h07, 32'h102, 1'b1, 1'b1);
    #1;
    n_cmp++; if (RLAST_M0 !== 1'b1 || RDATA_M0 !== 32'h102) begin n_bad++; $display("FAIL bp_last: got %b/%h want 1/102", RLAST_M0, RDATA_M0); end
    tick();
    drive(0, 8'h00, 32'h0, 1'b0, 1'b0);
    #1;
    n_cmp++; if (RDATA_M0 !== 32'h900 || RREADY_S1 !== 1'b1) begin n_bad++; $display("FAIL bp_next: got %h/%b want 900/1", RDATA_M0, RREADY_S1); end
    tick();
    idle_all();
  endtask

  task automatic test_unmapped;
    drive(2, 8'hF0, 32'hDEAD, 1'b1, 1'b1);
    #1;
    n_cmp++; if (RREADY_S2 !== 1'b1 || unmapped_err !== 1'b1) begin n_bad++; $display("FAIL unm_sink: got %b/%b want 1/1", RREADY_S2, unmapped_err); end
    n_cmp++; if ({RVALID_M1, RVALID_M0} !== 2'b00) begin n_bad++; $display("FAIL unm_mvalid: got %b want 00", {RVALID_M1, RVALID_M0}); end
    tick();
    drive(2, 8'h00, 32'h0, 1'b0, 1'b0);
    #1;
    n_cmp++; if (unmapped_err !== 1'b0 || RREADY_S2 !== 1'b0) begin n_bad++; $display("FAIL unm_pulse_end: got %b/%b want 0/0", unmapped_err, RREADY_S2); end
    drive(1, 8'h20, 32'h1, 1'b1, 1'b1);
    drive(2, 8'h30, 32'h2, 1'b1, 1'b1);
    #1;
    n_cmp++; if ({RREADY_S2, RREADY_S1} !== 2'b01) begin n_bad++; $display("FAIL unm_order1: got %b want 01", {RREADY_S2, RREADY_S1}); end
    tick();
    drive(1, 8'h00, 32'h0, 1'b0, 1'b0);
    #1;
    n_cmp++; if (RREADY_S2 !== 1'b1 || unmapped_err !== 1'b1) begin n_bad++; $display("FAIL unm_order2: got %b/%b want 1/1", RREADY_S2, unmapped_err); end
    tick();
    idle_all();
    drive(0, 8'h03, 32'h33, 1'b0, 1'b1);
    tick();
    drive(0, 8'hE0, 32'h34, 1'b1, 1'b1);
    #1;
    n_cmp++; if (RREADY_S0 !== 1'b0 || unmapped_err !== 1'b0) begin n_bad++; $display("FAIL unm_locked: got %b/%b want 0/0", RREADY_S0, unmapped_err); end
    drive(0, 8'h03, 32'h35, 1'b1, 1'b1);
    tick();
    idle_all();
  endtask

  task automatic test_reset_mid_burst;
    drive(1, 8'h13, 32'h300, 1'b0, 1'b1);
    #1;
    n_cmp++; if (RVALID_M1 !== 1'b1) begin n_bad++; $display("FAIL rmb_beat1: got %b want 1", RVALID_M1); end
    tick();
    drive(1, 8'h13, 32'h301, 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    n_cmp++; if ({RVALID_M1, RVALID_M0, RREADY_S1} !== 3'b000) begin n_bad++; $display("FAIL rmb_force: got %b want 000", {RVALID_M1, RVALID_M0, RREADY_S1}); end
    tick();
    rst = 1'b0;
    drive(1, 8'h00, 32'h0, 1'b0, 1'b0);
    drive(2, 8'h15, 32'h500, 1'b1, 1'b1);
    #1;
    n_cmp++; if (RDATA_M1 !== 32'h500 || RID_M1 !== 4'h5 || RREADY_S2 !== 1'b1) begin n_bad++; $display("FAIL rmb_idle: got %h/%h/%b want 500/5/1", RDATA_M1, RID_M1, RREADY_S2); end
    tick();
    drive(2, 8'h00, 32'h0, 1'b0, 1'b0);
    drive(1, 8'h14, 32'h400, 1'b0, 1'b1);
    #1;
    n_cmp++; if (RDATA_M1 !== 32'h400 || RID_M1 !== 4'h4) begin n_bad++; $display("FAIL rmb_new1: got %h/%h want 400/4", RDATA_M1, RID_M1); end
    tick();
    drive(1, 8'h14, 32'h401, 1'b1, 1'b1);
    #1;
    n_cmp++; if (RLAST_M1 !== 1'b1 || RDATA_M1 !== 32'h401) begin n_bad++; $display("FAIL rmb_new2: got %b/%h want 1/401", RLAST_M1, RDATA_M1); end
    tick();
    idle_all();
  endtask

  initial begin
    test_reset();
    test_s1_burst();
    test_concurrent();
    test_priority();
    test_backpressure();
    test_unmapped();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
